// File: rtl/trace_pkg.sv
// Shared types for the write-back trace checker: FSM states, error codes, trace entry layout.
// Trace entry packing is {pc, 8-bit register field, data}, data in the low bits.
package trace_pkg;

  typedef enum logic [1:0] {
    ST_CHECK = 2'd0,
    ST_PASS  = 2'd1,
    ST_FAIL  = 2'd2
  } state_e;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISMATCH = 2'd1;
  localparam logic [1:0] ERR_OVERRUN  = 2'd2;
  localparam logic [1:0] ERR_FINAL    = 2'd3;

  localparam int ADDR_FIELD_W = 8;

  function automatic int addr_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int pc_lsb(input int data_w);
    return data_w + ADDR_FIELD_W;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Golden trace store: one synchronous write port, RD_PORTS combinational read ports.
// Contents survive reset; a write is visible to readers from the following cycle, no backpressure.
module trace_ram #(
  parameter int DEPTH    = 1024,
  parameter int W        = 72,
  parameter int RD_PORTS = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [W-1:0]           wdata,
  input  logic [RD_PORTS*AW-1:0] raddr,
  output logic [RD_PORTS*W-1:0]  rdata
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_comb begin
    rdata = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      rdata[p*W +: W] = mem_q[raddr[p*AW +: AW]];
    end
  end

endmodule

// File: rtl/wb_trace_checker.sv
// Compares up to CHANNELS retiring register writes per cycle against a loaded golden trace.
// Status is registered one edge after the commits; commits are never stalled (no backpressure).
module wb_trace_checker
  import trace_pkg::*;
#(
  parameter int              PC_W        = 32,
  parameter int              ADDR_W      = 5,
  parameter int              DATA_W      = 32,
  parameter int              DEPTH       = 1024,
  parameter int              CHANNELS    = 1,
  parameter int              TEST_COUNT  = 1,
  parameter logic [PC_W-1:0] FINAL_PC    = '0,
  parameter bit              STOP_ON_ERR = 1'b1,
  parameter int              LED_W       = 16,
  localparam int             AW          = $clog2(DEPTH),
  localparam int             EW          = PC_W + ADDR_FIELD_W + DATA_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [CHANNELS-1:0]        wb_valid,
  input  logic [CHANNELS*PC_W-1:0]   wb_pc,
  input  logic [CHANNELS-1:0]        wb_wen,
  input  logic [CHANNELS*ADDR_W-1:0] wb_addr,
  input  logic [CHANNELS*DATA_W-1:0] wb_wdata,
  input  logic                       tl_we,
  input  logic [AW-1:0]              tl_addr,
  input  logic [EW-1:0]              tl_data,
  output logic                       done,
  output logic                       pass,
  output logic                       fail,
  output logic [1:0]                 err_code,
  output logic [15:0]                err_count,
  output logic [PC_W-1:0]            err_pc,
  output logic [ADDR_W-1:0]          err_addr,
  output logic [DATA_W-1:0]          err_data,
  output logic [15:0]                ref_index,
  output logic [LED_W-1:0]           leds
);

  localparam int                          CNT_W     = AW + 1;
  localparam logic [CNT_W-1:0]            TC        = CNT_W'(TEST_COUNT);
  localparam int                          A_LSB     = addr_lsb(DATA_W);
  localparam int                          P_LSB     = pc_lsb(DATA_W);
  localparam logic [ADDR_FIELD_W-1:0]     ADDR_MASK = ADDR_FIELD_W'((1 << ADDR_W) - 1);

  logic [CHANNELS*AW-1:0] rd_addr;
  logic [CHANNELS*EW-1:0] rd_data;
  logic [CHANNELS-1:0]    qual;
  logic [CNT_W-1:0]       ch_idx [CHANNELS];
  logic [CNT_W-1:0]       run_idx;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [1:0]           err_code_q, err_code_d;
  logic [15:0]          err_count_q, err_count_d;
  logic [PC_W-1:0]      err_pc_q, err_pc_d;
  logic [ADDR_W-1:0]    err_addr_q, err_addr_d;
  logic [DATA_W-1:0]    err_data_q, err_data_d;
  logic [15:0]          ref_index_q, ref_index_d;
  logic                 done_q, done_d, pass_q, pass_d, fail_q, fail_d;
  logic [LED_W-1:0]     leds_q, leds_d;

  logic                 stop, fin, fail_now, mism;
  logic [EW-1:0]        entry;
  logic [PC_W-1:0]      pc_c;
  logic [ADDR_W-1:0]    addr_c;
  logic [DATA_W-1:0]    data_c;

  trace_ram #(
    .DEPTH    (DEPTH),
    .W        (EW),
    .RD_PORTS (CHANNELS)
  ) u_ram (
    .clk   (clk),
    .we    (tl_we),
    .waddr (tl_addr),
    .wdata (tl_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // A final-PC commit is never compared, so it never claims a trace slot.
  always_comb begin
    qual    = '0;
    rd_addr = '0;
    run_idx = count_q;
    for (int c = 0; c < CHANNELS; c++) begin
      qual[c]   = wb_valid[c] & wb_wen[c] & (wb_addr[c*ADDR_W +: ADDR_W] != '0)
                & (wb_pc[c*PC_W +: PC_W] != FINAL_PC);
      ch_idx[c] = run_idx;
      rd_addr[c*AW +: AW] = run_idx[AW-1:0];
      if (qual[c]) run_idx = run_idx + CNT_W'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    err_code_d  = err_code_q;
    err_count_d = err_count_q;
    err_pc_d    = err_pc_q;
    err_addr_d  = err_addr_q;
    err_data_d  = err_data_q;
    ref_index_d = ref_index_q;
    stop        = 1'b0;
    fin         = 1'b0;
    fail_now    = 1'b0;
    mism        = 1'b0;
    entry       = '0;
    pc_c        = '0;
    addr_c      = '0;
    data_c      = '0;

    if (state_q == ST_CHECK) begin
      // Channels are walked oldest first; a final PC or a stopping error masks younger ones.
      for (int c = 0; c < CHANNELS; c++) begin
        if (!stop && wb_valid[c]) begin
          pc_c   = wb_pc[c*PC_W +: PC_W];
          addr_c = wb_addr[c*ADDR_W +: ADDR_W];
          data_c = wb_wdata[c*DATA_W +: DATA_W];
          entry  = rd_data[c*EW +: EW];
          if (pc_c == FINAL_PC) begin
            fin  = 1'b1;
            stop = 1'b1;
          end else if (qual[c]) begin
            if (ch_idx[c] >= TC) begin
              fail_now = 1'b1;
              stop     = 1'b1;
              if (err_code_d == ERR_NONE) begin
                err_code_d  = ERR_OVERRUN;
                err_pc_d    = pc_c;
                err_addr_d  = addr_c;
                err_data_d  = data_c;
                ref_index_d = 16'(ch_idx[c]);
              end
            end else begin
              count_d = count_d + CNT_W'(1);
              mism = (entry[P_LSB +: PC_W] != pc_c)
                   || ((entry[A_LSB +: ADDR_FIELD_W] & ADDR_MASK) != ADDR_FIELD_W'(addr_c))
                   || (entry[DATA_W-1:0] != data_c);
              if (mism) begin
                if (err_code_d == ERR_NONE) begin
                  err_code_d  = ERR_MISMATCH;
                  err_pc_d    = pc_c;
                  err_addr_d  = addr_c;
                  err_data_d  = data_c;
                  ref_index_d = 16'(ch_idx[c]);
                end
                if (STOP_ON_ERR) begin
                  fail_now = 1'b1;
                  stop     = 1'b1;
                end else if (err_count_d != 16'hFFFF) begin
                  err_count_d = err_count_d + 16'd1;
                end
              end
            end
          end
        end
      end

      if (fail_now) begin
        state_d = ST_FAIL;
      end else if (fin) begin
        if (count_d == TC && err_count_d == 16'd0) begin
          state_d = ST_PASS;
        end else begin
          state_d = ST_FAIL;
          if (err_code_d == ERR_NONE) err_code_d = ERR_FINAL;
        end
      end
    end

    done_d = (state_d != ST_CHECK);
    pass_d = (state_d == ST_PASS);
    fail_d = (state_d == ST_FAIL);
    leds_d = '1;
    if (state_d == ST_PASS) begin
      leds_d = '0;
    end else if (state_d == ST_FAIL) begin
      leds_d[7:0] = (err_count_d > 16'd255) ? 8'hFF : err_count_d[7:0];
      for (int i = 8; i < LED_W; i++) leds_d[i] = err_code_d[i[0]];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_CHECK;
      count_q     <= '0;
      err_code_q  <= ERR_NONE;
      err_count_q <= '0;
      err_pc_q    <= '0;
      err_addr_q  <= '0;
      err_data_q  <= '0;
      ref_index_q <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      leds_q      <= '1;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      err_code_q  <= err_code_d;
      err_count_q <= err_count_d;
      err_pc_q    <= err_pc_d;
      err_addr_q  <= err_addr_d;
      err_data_q  <= err_data_d;
      ref_index_q <= ref_index_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      leds_q      <= leds_d;
    end
  end

  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign err_code  = err_code_q;
  assign err_count = err_count_q;
  assign err_pc    = err_pc_q;
  assign err_addr  = err_addr_q;
  assign err_data  = err_data_q;
  assign ref_index = ref_index_q;
  assign leds      = leds_q;

endmodule

// File: tb/tb_wb_trace_checker.sv
// Bench: two checker instances (2-channel stop-on-error, 1-channel keep-counting) sharing one stimulus bus;
// expected status is queued with each stimulus cycle and compared one edge later.
module tb_wb_trace_checker;

  localparam int          AW  = 4;
  localparam logic [31:0] FPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_a_n, rst_b_n;
  logic [1:0]  wb_valid, wb_wen;
  logic [63:0] wb_pc, wb_wdata;
  logic [9:0]  wb_addr;
  logic        tl_we;
  logic [AW-1:0] tl_addr;
  logic [71:0] tl_data;

  logic        a_done, a_pass, a_fail, b_done, b_pass, b_fail;
  logic [1:0]  a_code, b_code;
  logic [15:0] a_cnt, b_cnt, a_ref, b_ref, a_leds, b_leds;
  logic [31:0] a_pc, b_pc, a_data, b_data;
  logic [4:0]  a_addr, b_addr;

  always #5 clk = ~clk;

  wb_trace_checker #(
    .PC_W(32), .ADDR_W(5), .DATA_W(32), .DEPTH(16), .CHANNELS(2), .TEST_COUNT(3),
    .FINAL_PC(FPC), .STOP_ON_ERR(1'b1), .LED_W(16)
  ) u_dut_a (
    .clk(clk), .reset(rst_a_n), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_wen(wb_wen),
    .wb_addr(wb_addr), .wb_wdata(wb_wdata), .tl_we(tl_we), .tl_addr(tl_addr), .tl_data(tl_data),
    .done(a_done), .pass(a_pass), .fail(a_fail), .err_code(a_code), .err_count(a_cnt),
    .err_pc(a_pc), .err_addr(a_addr), .err_data(a_data), .ref_index(a_ref), .leds(a_leds)
  );

  wb_trace_checker #(
    .PC_W(32), .ADDR_W(5), .DATA_W(32), .DEPTH(16), .CHANNELS(1), .TEST_COUNT(3),
    .FINAL_PC(FPC), .STOP_ON_ERR(1'b0), .LED_W(16)
  ) u_dut_b (
    .clk(clk), .reset(rst_b_n), .wb_valid(wb_valid[0:0]), .wb_pc(wb_pc[31:0]), .wb_wen(wb_wen[0:0]),
    .wb_addr(wb_addr[4:0]), .wb_wdata(wb_wdata[31:0]), .tl_we(tl_we), .tl_addr(tl_addr), .tl_data(tl_data),
    .done(b_done), .pass(b_pass), .fail(b_fail), .err_code(b_code), .err_count(b_cnt),
    .err_pc(b_pc), .err_addr(b_addr), .err_data(b_data), .ref_index(b_ref), .leds(b_leds)
  );

  typedef struct {
    bit          sel;
    logic        done, pass, fail;
    logic [1:0]  code;
    bit          chk_cnt;
    logic [15:0] cnt, leds;
    bit          chk_fld;
    logic [15:0] ref_idx;
    logic [31:0] epc;
    logic [4:0]  eaddr;
    logic [31:0] edata;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input bit sel, input logic d, input logic p, input logic f,
                      input logic [1:0] code, input bit chk_cnt, input logic [15:0] cnt,
                      input logic [15:0] leds, input bit chk_fld, input logic [15:0] ref_idx,
                      input logic [31:0] epc, input logic [4:0] eaddr, input logic [31:0] edata);
    exp_t e;
    e.sel = sel; e.done = d; e.pass = p; e.fail = f; e.code = code;
    e.chk_cnt = chk_cnt; e.cnt = cnt; e.leds = leds;
    e.chk_fld = chk_fld; e.ref_idx = ref_idx; e.epc = epc; e.eaddr = eaddr; e.edata = edata;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic exp_run(input string tag, input bit sel, input logic [1:0] code, input logic [15:0] cnt);
    push(tag, sel, 1'b0, 1'b0, 1'b0, code, 1'b1, cnt, 16'hFFFF, 1'b0, '0, '0, '0, '0);
  endtask

  task automatic exp_end(input string tag, input bit sel, input logic p, input logic [1:0] code,
                         input logic [15:0] cnt, input logic [15:0] leds);
    push(tag, sel, 1'b1, p, !p, code, 1'b1, cnt, leds, 1'b0, '0, '0, '0, '0);
  endtask

  task automatic exp_err(input string tag, input bit sel, input logic [1:0] code, input logic [15:0] ref_idx,
                         input logic [31:0] epc, input logic [4:0] eaddr, input logic [31:0] edata);
    push(tag, sel, 1'b1, 1'b0, 1'b1, code, 1'b0, '0, '0, 1'b1, ref_idx, epc, eaddr, edata);
  endtask

  task automatic drain();
    exp_t  e;
    string t;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      if (!e.sel) begin
        chk_eq({t, ".done"}, a_done, e.done);
        chk_eq({t, ".pass"}, a_pass, e.pass);
        chk_eq({t, ".fail"}, a_fail, e.fail);
        chk_eq({t, ".code"}, a_code, e.code);
        if (e.chk_cnt) begin
          chk_eq({t, ".err_count"}, a_cnt, e.cnt);
          chk_eq({t, ".leds"}, a_leds, e.leds);
        end
        if (e.chk_fld) begin
          chk_eq({t, ".ref_index"}, a_ref, e.ref_idx);
          chk_eq({t, ".err_pc"}, a_pc, e.epc);
          chk_eq({t, ".err_addr"}, a_addr, e.eaddr);
          chk_eq({t, ".err_data"}, a_data, e.edata);
        end
      end else begin
        chk_eq({t, ".done"}, b_done, e.done);
        chk_eq({t, ".pass"}, b_pass, e.pass);
        chk_eq({t, ".fail"}, b_fail, e.fail);
        chk_eq({t, ".code"}, b_code, e.code);
        if (e.chk_cnt) begin
          chk_eq({t, ".err_count"}, b_cnt, e.cnt);
          chk_eq({t, ".leds"}, b_leds, e.leds);
        end
        if (e.chk_fld) begin
          chk_eq({t, ".ref_index"}, b_ref, e.ref_idx);
          chk_eq({t, ".err_pc"}, b_pc, e.epc);
          chk_eq({t, ".err_addr"}, b_addr, e.eaddr);
          chk_eq({t, ".err_data"}, b_data, e.edata);
        end
      end
    end
  endtask

  task automatic idle();
    wb_valid = '0; wb_wen = '0; wb_pc = '0; wb_addr = '0; wb_wdata = '0;
  endtask

  task automatic com(input int c, input logic [31:0] pc, input logic [4:0] addr, input logic [31:0] data);
    wb_valid[c] = 1'b1;
    wb_wen[c]   = 1'b1;
    wb_pc[c*32 +: 32]    = pc;
    wb_addr[c*5 +: 5]    = addr;
    wb_wdata[c*32 +: 32] = data;
  endtask

  function automatic logic [31:0] tpc(input int i);
    return 32'h10 + 32'(4 * i);
  endfunction

  function automatic logic [31:0] tdat(input int i);
    return 32'hA0 + 32'(i);
  endfunction

  task automatic ent(input int c, input int i);
    com(c, tpc(i), 5'(i + 1), tdat(i));
  endtask

  task automatic fin(input int c);
    wb_valid[c] = 1'b1;
    wb_wen[c]   = 1'b0;
    wb_pc[c*32 +: 32] = FPC;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drain();
    idle();
  endtask

  task automatic reset_dut(input bit sel, input string tag);
    if (!sel) rst_a_n = 1'b0; else rst_b_n = 1'b0;
    #1;
    push(tag, sel, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 16'h0, 16'hFFFF, 1'b1, 16'h0, '0, '0, '0);
    drain();
    #1;
    if (!sel) rst_a_n = 1'b1; else rst_b_n = 1'b1;
  endtask

  task automatic run_pass_a(input string tag);
    for (int i = 0; i < 3; i++) begin
      ent(0, i); exp_run({tag, "_c"}, 1'b0, 2'd0, 16'd0); tick();
    end
    fin(0); exp_end({tag, "_fin"}, 1'b0, 1'b1, 2'd0, 16'd0, 16'h0000); tick();
    exp_end({tag, "_hold"}, 1'b0, 1'b1, 2'd0, 16'd0, 16'h0000); tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by time limit, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    tl_we = 1'b0; tl_addr = '0; tl_data = '0;
    idle();
    for (int i = 0; i < 3; i++) begin
      tl_we = 1'b1; tl_addr = AW'(i); tl_data = {tpc(i), 8'(i + 1), tdat(i)};
      @(posedge clk); #1;
    end
    tl_we = 1'b0;
    rst_a_n = 1'b1; rst_b_n = 1'b1;
    reset_dut(1'b0, "rst_a");
    reset_dut(1'b1, "rst_b");

    run_pass_a("pass1");

    reset_dut(1'b0, "rst_a2");
    ent(0, 0); exp_run("mm_c0", 1'b0, 2'd0, 16'd0); tick();
    com(0, tpc(1), 5'd2, 32'hDEAD); exp_err("mm_bad", 1'b0, 2'd1, 16'd1, tpc(1), 5'd2, 32'hDEAD); tick();
    ent(0, 2); exp_err("mm_hold", 1'b0, 2'd1, 16'd1, tpc(1), 5'd2, 32'hDEAD); tick();

    #2;
    reset_dut(1'b0, "rst_mid");
    run_pass_a("rerun");

    reset_dut(1'b0, "rst_a3");
    ent(0, 0); exp_run("ov_c0", 1'b0, 2'd0, 16'd0); tick();
    com(0, 32'h50, 5'd0, 32'h1234); exp_run("ov_r0", 1'b0, 2'd0, 16'd0); tick();
    ent(0, 1); exp_run("ov_c1", 1'b0, 2'd0, 16'd0); tick();
    ent(0, 2); exp_run("ov_c2", 1'b0, 2'd0, 16'd0); tick();
    com(0, 32'h1C, 5'd4, 32'hA3);
    exp_err("ov_4th", 1'b0, 2'd2, 16'd3, 32'h1C, 5'd4, 32'hA3);
    exp_end("ov_leds", 1'b0, 1'b0, 2'd2, 16'd0, 16'hAA00);
    tick();

    reset_dut(1'b0, "rst_a4");
    ent(0, 0); ent(1, 1); exp_run("dual_01", 1'b0, 2'd0, 16'd0); tick();
    ent(0, 2); fin(1); exp_end("dual_fin", 1'b0, 1'b1, 2'd0, 16'd0, 16'h0000); tick();

    reset_dut(1'b0, "rst_a5");
    ent(0, 0); com(1, tpc(1), 5'd2, tdat(0));
    exp_err("swap", 1'b0, 2'd1, 16'd1, tpc(1), 5'd2, tdat(0)); tick();

    reset_dut(1'b0, "rst_a6");
    ent(0, 0); exp_run("sim_c0", 1'b0, 2'd0, 16'd0); tick();
    ent(0, 1); exp_run("sim_c1", 1'b0, 2'd0, 16'd0); tick();
    com(0, tpc(2), 5'd3, 32'hBAD2); fin(1);
    exp_err("sim_fin", 1'b0, 2'd1, 16'd2, tpc(2), 5'd3, 32'hBAD2); tick();

    reset_dut(1'b1, "rst_b2");
    com(0, tpc(0), 5'd1, 32'hBAD0);
    push("nostop_e0", 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 16'd1, 16'hFFFF,
         1'b1, 16'd0, tpc(0), 5'd1, 32'hBAD0);
    tick();
    ent(0, 1); exp_run("nostop_c1", 1'b1, 2'd1, 16'd1); tick();
    com(0, tpc(2), 5'd3, 32'hBAD2); exp_run("nostop_e2", 1'b1, 2'd1, 16'd2); tick();
    fin(0);
    exp_end("nostop_fin", 1'b1, 1'b0, 2'd1, 16'd2, 16'h5502);
    push("nostop_first", 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, '0, '0, 1'b1, 16'd0, tpc(0), 5'd1, 32'hBAD0);
    tick();

    reset_dut(1'b1, "rst_b3");
    ent(0, 0); exp_run("short_c0", 1'b1, 2'd0, 16'd0); tick();
    fin(0); exp_end("short_fin", 1'b1, 1'b0, 2'd3, 16'd0, 16'hFF00); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
